// File: rtl/rom_loader.sv
// Copies a byte image from a combinational ROM into a write-handshaked sink, then releases cpu_reset_n.
// Optional running checksum of written bytes is built only when ROM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] MAX_BYTES = 32'd4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_byte,
    input  logic        rom_done,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic        busy,
    output logic        load_done,
    output logic        error,
    output logic        cpu_reset_n,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state_reg;
    logic [31:0] count_reg;
    logic [31:0] count_next;
    logic        last_reg;
    logic [7:0]  mem_data_reg;
    logic        valid_reg;
    logic        busy_reg;
    logic        load_done_reg;
    logic        error_reg;
    logic        cpu_reset_n_reg;
    logic        accept;

    assign count_next = count_reg + 32'd1;
    assign accept     = valid_reg & mem_wr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            count_reg       <= 32'd0;
            last_reg        <= 1'b0;
            mem_data_reg    <= 8'd0;
            valid_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            load_done_reg   <= 1'b0;
            error_reg       <= 1'b0;
            cpu_reset_n_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= FETCH;
                        count_reg <= 32'd0;
                        busy_reg  <= 1'b1;
                    end
                end
                FETCH: begin
                    mem_data_reg <= rom_byte;
                    last_reg     <= rom_done;
                    valid_reg    <= 1'b1;
                    state_reg    <= WRITE;
                end
                WRITE: begin
                    // address and data registers stay untouched until the sink accepts
                    if (mem_wr_ready) begin
                        valid_reg <= 1'b0;
                        if (last_reg) begin
                            state_reg       <= DONE;
                            busy_reg        <= 1'b0;
                            load_done_reg   <= 1'b1;
                            cpu_reset_n_reg <= 1'b1;
                        end else if (count_next == MAX_BYTES) begin
                            state_reg <= FAULT;
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                        end else begin
                            count_reg <= count_next;
                            state_reg <= FETCH;
                        end
                    end
                end
                default: begin
                    // DONE and FAULT are terminal until reset
                end
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_reg <= 8'd0;
        end else if (accept) begin
            checksum_reg <= checksum_reg + mem_data_reg;
        end
    end

    assign checksum = checksum_reg;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign checksum      = 8'd0;
`endif

    assign rom_address  = count_reg;
    assign mem_addr     = BASE_ADDR + count_reg;
    assign mem_data     = mem_data_reg;
    assign mem_wr_valid = valid_reg;
    assign busy         = busy_reg;
    assign load_done    = load_done_reg;
    assign error        = error_reg;
    assign cpu_reset_n  = cpu_reset_n_reg;

endmodule
